// File: rtl/frame_flusher_if.sv
// Purpose: bundles the frame_flusher control, sprite-lookup and VGA-write signals.
// Ports:   start/layer_enable/layer_colour flow into the flusher; flush_x/y, vga_x/y,
//          vga_colour, vga_plot, busy, done and frame_count flow out of it.
interface frame_flusher_if;
  logic       start;
  logic       layer_enable;
  logic [5:0] layer_colour;
  logic [7:0] flush_x;
  logic [7:0] flush_y;
  logic [7:0] vga_x;
  logic [7:0] vga_y;
  logic [5:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;
  logic [7:0] frame_count;

  // master: the flusher itself
  modport master (
    input  start, layer_enable, layer_colour,
    output flush_x, flush_y, vga_x, vga_y, vga_colour, vga_plot, busy, done, frame_count
  );

  // slave: game FSM + sprite logic + VGA adapter side
  modport slave (
    output start, layer_enable, layer_colour,
    input  flush_x, flush_y, vga_x, vga_y, vga_colour, vga_plot, busy, done, frame_count
  );
endinterface

// File: rtl/frame_flusher.sv
// Purpose: full-screen raster scanner; sweeps flush_x/y over every pixel, merges the
//          sprite layer result and issues one VGA write per pixel.
// Ports:   clock, resetn (async active-low); bus (frame_flusher_if.master) carries
//          start, layer_enable/colour in and flush_x/y, vga_*, busy, done, frame_count out.
// Latency: one cycle from flush_x/y to the matching vga_x/y/colour/plot.
// Backpressure: none; the VGA adapter accepts a write every cycle, start is ignored while busy.
module frame_flusher #(
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120,
  parameter logic [5:0] BG_COLOUR = 6'b000000
) (
  input  logic           clock,
  input  logic           resetn,
  frame_flusher_if.master bus
);

  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [7:0] Y_LAST = 8'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [7:0] fc_q, fc_d;
  logic [7:0] vx_q, vx_d;
  logic [7:0] vy_q, vy_d;
  logic [5:0] vc_q, vc_d;
  logic       plot_q, plot_d;

  // Scan counters and frame sequencing
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    fc_d    = fc_q;
    case (state_q)
      IDLE: begin
        x_d = 8'd0;
        y_d = 8'd0;
        if (bus.start) state_d = SCAN;
      end
      SCAN: begin
        if (x_q == X_LAST) begin
          x_d = 8'd0;
          if (y_q == Y_LAST) begin
            // last pixel issued this cycle; park the scan at the origin
            y_d     = 8'd0;
            state_d = DRAIN;
          end else begin
            y_d = y_q + 8'd1;
          end
        end else begin
          x_d = x_q + 8'd1;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        fc_d    = fc_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel pipeline: capture the scan position and merged colour while scanning,
  // otherwise hold the last written pixel with the strobe low.
  always_comb begin
    plot_d = (state_q == SCAN);
    vx_d   = vx_q;
    vy_d   = vy_q;
    vc_d   = vc_q;
    if (state_q == SCAN) begin
      vx_d = x_q;
      vy_d = y_q;
      vc_d = bus.layer_enable ? bus.layer_colour : BG_COLOUR;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      fc_q    <= 8'd0;
      vx_q    <= 8'd0;
      vy_q    <= 8'd0;
      vc_q    <= 6'd0;
      plot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fc_q    <= fc_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vc_q    <= vc_d;
      plot_q  <= plot_d;
    end
  end

  assign bus.flush_x     = x_q;
  assign bus.flush_y     = y_q;
  assign bus.vga_x       = vx_q;
  assign bus.vga_y       = vy_q;
  assign bus.vga_colour  = vc_q;
  assign bus.vga_plot    = plot_q;
  assign bus.busy        = (state_q == SCAN) || (state_q == DRAIN);
  assign bus.done        = (state_q == DONE);
  assign bus.frame_count = fc_q;

endmodule

// File: tb/tb_frame_flusher.sv
// Purpose: self-checking bench for frame_flusher; a full-size instance for frame timing,
//          sprite merge and reset, and a 5x3 instance for back-to-back frames and wrap.
// Ports:   none (top-level bench).
module tb_frame_flusher;

  localparam int BW = 160;
  localparam int BH = 120;
  localparam int SW = 5;
  localparam int SH = 3;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  logic start_v [2];
  int   mode_v  [2];
  bit   chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  frame_flusher_if big_if ();
  frame_flusher_if small_if ();

  frame_flusher dut_big (
    .clock  (clock),
    .resetn (resetn),
    .bus    (big_if)
  );

  frame_flusher #(.SCREEN_W(SW), .SCREEN_H(SH), .BG_COLOUR(6'b000000)) dut_small (
    .clock  (clock),
    .resetn (resetn),
    .bus    (small_if)
  );

  // Sprite stand-in: mode 0 none, mode 1 one red pixel at (10,20) with a non-zero
  // colour elsewhere that must be masked, mode 2 checkerboard of varying colours.
  function automatic logic [6:0] sprite(input int mode, input int x, input int y);
    logic [6:0] r;
    r = 7'b0;
    if (mode == 1) begin
      r = (x == 10 && y == 20) ? 7'b1110000 : 7'b0111111;
    end else if (mode == 2) begin
      r[6]   = ((x + y) % 2) == 1;
      r[5:0] = 6'((x * 3 + y) % 64);
    end
    return r;
  endfunction

  function automatic logic [5:0] exp_col(input int mode, input int x, input int y);
    logic [6:0] s;
    s = sprite(mode, x, y);
    return s[6] ? s[5:0] : 6'b000000;
  endfunction

  function automatic int wd(input int d);
    return (d == 0) ? BW : SW;
  endfunction

  function automatic int ht(input int d);
    return (d == 0) ? BH : SH;
  endfunction

  assign big_if.start   = start_v[0];
  assign small_if.start = start_v[1];
  assign {big_if.layer_enable, big_if.layer_colour} =
    sprite(mode_v[0], int'(big_if.flush_x), int'(big_if.flush_y));
  assign {small_if.layer_enable, small_if.layer_colour} =
    sprite(mode_v[1], int'(small_if.flush_x), int'(small_if.flush_y));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: mk = cycles since start was accepted (0 = idle). Cycle k of a frame
  // scans pixel k-1, plots pixel k-2, pulses done at N+2 and is idle again at N+3.
  int         mk    [2] = '{0, 0};
  logic [7:0] mfc   [2] = '{8'd0, 8'd0};
  bit         mever [2] = '{1'b0, 1'b0};
  logic [5:0] mlc   [2] = '{6'd0, 6'd0};

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int d = 0; d < 2; d++) begin
        mk[d]    <= 0;
        mfc[d]   <= 8'd0;
        mever[d] <= 1'b0;
        mlc[d]   <= 6'd0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (mk[d] == 0) begin
          if (((d == 0) ? big_if.start : small_if.start) == 1'b1) mk[d] <= 1;
        end else if (mk[d] == wd(d) * ht(d) + 2) begin
          mk[d]  <= 0;
          mfc[d] <= mfc[d] + 8'd1;
        end else begin
          mk[d] <= mk[d] + 1;
        end
        if (mk[d] == 1) mever[d] <= 1'b1;
        if (mk[d] == wd(d) * ht(d)) mlc[d] <= exp_col(mode_v[d], wd(d) - 1, ht(d) - 1);
      end
    end
  end

  task automatic cmp(input int d, input string pf,
                     input logic [7:0] fx, input logic [7:0] fy,
                     input logic [7:0] vx, input logic [7:0] vy, input logic [5:0] vc,
                     input logic pl, input logic bs, input logic dn, input logic [7:0] fc);
    int w, h, n, k, p, efx, efy, evx, evy;
    logic [5:0] evc;
    logic epl;
    w = wd(d); h = ht(d); n = w * h; k = mk[d];
    efx = 0; efy = 0;
    if (k >= 1 && k <= n) begin
      efx = (k - 1) % w;
      efy = (k - 1) / w;
    end
    epl = (k >= 2 && k <= n + 1);
    if (epl) begin
      p = k - 2; evx = p % w; evy = p / w; evc = exp_col(mode_v[d], evx, evy);
    end else if (mever[d]) begin
      evx = w - 1; evy = h - 1; evc = mlc[d];
    end else begin
      evx = 0; evy = 0; evc = 6'd0;
    end
    chk({pf, " flush_x"}, fx, efx);
    chk({pf, " flush_y"}, fy, efy);
    chk({pf, " vga_x"}, vx, evx);
    chk({pf, " vga_y"}, vy, evy);
    chk({pf, " vga_colour"}, vc, evc);
    chk({pf, " vga_plot"}, pl, epl);
    chk({pf, " busy"}, bs, (k >= 1 && k <= n + 1));
    chk({pf, " done"}, dn, (k == n + 2));
    if (k != n + 2) chk({pf, " frame_count"}, fc, mfc[d]);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      cmp(0, "big", big_if.flush_x, big_if.flush_y, big_if.vga_x, big_if.vga_y,
          big_if.vga_colour, big_if.vga_plot, big_if.busy, big_if.done, big_if.frame_count);
      cmp(1, "small", small_if.flush_x, small_if.flush_y, small_if.vga_x, small_if.vga_y,
          small_if.vga_colour, small_if.vga_plot, small_if.busy, small_if.done,
          small_if.frame_count);
    end
  end

  // Cumulative monitors on the full-size instance
  int         plots_b = 0, nz_b = 0, done_b = 0, done_s = 0;
  int         max_fx = 0, max_fy = 0;
  logic [7:0] pfx = 8'd0, pfy = 8'd0;
  logic [5:0] cap_col = 6'd0;
  logic [15:0] cap_pf = 16'd0;

  always @(negedge clock) begin
    pfx <= big_if.flush_x;
    pfy <= big_if.flush_y;
    if (int'(big_if.flush_x) > max_fx) max_fx <= int'(big_if.flush_x);
    if (int'(big_if.flush_y) > max_fy) max_fy <= int'(big_if.flush_y);
    if (big_if.vga_plot) begin
      plots_b <= plots_b + 1;
      if (big_if.vga_colour != 6'd0) nz_b <= nz_b + 1;
      if (big_if.vga_x == 8'd10 && big_if.vga_y == 8'd20) begin
        cap_col <= big_if.vga_colour;
        cap_pf  <= {pfx, pfy};
      end
    end
    if (big_if.done) done_b <= done_b + 1;
    if (small_if.done) done_s <= done_s + 1;
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  // One full-size frame from a one-cycle start pulse, with literal timing checks.
  task automatic big_frame();
    int n;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    n = 1;
    chk("t1 flush origin", {big_if.flush_x, big_if.flush_y}, 16'h0000);
    chk("t1 busy", big_if.busy, 1'b1);
    while (big_if.done !== 1'b1 && n < 20000) begin
      tick();
      n++;
      case (n)
        2:     chk("first plot", {big_if.vga_plot, big_if.vga_x, big_if.vga_y}, {1'b1, 16'h0000});
        160:   chk("flush (159,0)", {big_if.flush_x, big_if.flush_y}, {8'd159, 8'd0});
        161:   chk("flush (0,1)", {big_if.flush_x, big_if.flush_y}, {8'd0, 8'd1});
        19040: chk("flush (159,118)", {big_if.flush_x, big_if.flush_y}, {8'd159, 8'd118});
        19041: chk("flush (0,119)", {big_if.flush_x, big_if.flush_y}, {8'd0, 8'd119});
        19201: chk("last plot", {big_if.vga_plot, big_if.busy, big_if.vga_x, big_if.vga_y},
                   {1'b1, 1'b1, 8'd159, 8'd119});
        19202: chk("done cycle plot/busy", {big_if.vga_plot, big_if.busy}, 2'b00);
        default: ;
      endcase
    end
    chk("done edge count", n, 19202);
    tick();
    chk("idle after done", {big_if.busy, big_if.done, big_if.vga_plot}, 3'b000);
  endtask

  initial begin
    int p0, nz0, d0, ds0, cyc, last, dn, pend, bad;
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    mode_v[0] = 0; mode_v[1] = 2;
    do_reset();
    chk_en = 1'b1;

    // reset state
    chk("reset big outputs",
        {big_if.flush_x, big_if.flush_y, big_if.vga_x, big_if.vga_y, big_if.vga_colour,
         big_if.vga_plot, big_if.busy, big_if.done, big_if.frame_count}, 0);

    // single frame, background only
    p0 = plots_b; nz0 = nz_b;
    big_frame();
    chk("plots frame 1", plots_b - p0, 19200);
    chk("non-bg pixels frame 1", nz_b - nz0, 0);
    chk("frame_count after 1", big_if.frame_count, 8'd1);

    // sprite merge at (10,20)
    mode_v[0] = 1;
    p0 = plots_b; nz0 = nz_b;
    big_frame();
    chk("plots frame 2", plots_b - p0, 19200);
    chk("non-bg pixels frame 2", nz_b - nz0, 1);
    chk("sprite colour at (10,20)", cap_col, 6'b110000);
    chk("flush one cycle before plot", cap_pf, {8'd10, 8'd20});
    chk("frame_count after 2", big_if.frame_count, 8'd2);
    chk("max flush_x", max_fx, 159);
    chk("max flush_y", max_fy, 119);

    // reset mid-scan at (37,12)
    d0 = done_b;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    cyc = 0;
    while (!(big_if.flush_x == 8'd37 && big_if.flush_y == 8'd12) && cyc < 3000) begin
      tick();
      cyc++;
    end
    chk("reached (37,12)", {big_if.flush_x, big_if.flush_y}, {8'd37, 8'd12});
    resetn = 1'b0;
    #1;
    chk("mid-frame reset outputs",
        {big_if.flush_x, big_if.flush_y, big_if.vga_x, big_if.vga_y, big_if.vga_colour,
         big_if.vga_plot, big_if.busy, big_if.done, big_if.frame_count}, 0);
    tick();
    resetn = 1'b1;
    repeat (20) tick();
    chk("no done after abort", done_b - d0, 0);
    chk("idle after abort", {big_if.busy, big_if.frame_count}, 0);

    // small instance: start during SCAN and DONE ignored
    ds0 = done_s;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    repeat (4) tick();
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    cyc = 0;
    while (small_if.done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("small done seen", small_if.done, 1'b1);
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    repeat (6) tick();
    chk("single done", done_s - ds0, 1);
    chk("small idle after ignored start", small_if.busy, 1'b0);
    chk("small frame_count +1", small_if.frame_count, 8'd1);

    // back-to-back frames with start held, frame_count wrap
    do_reset();
    start_v[1] = 1'b1;
    cyc = 0; last = 0; dn = 0; pend = 0; bad = 0;
    while ((dn < 257 || pend != 0) && cyc < 257 * 18 + 100) begin
      tick();
      cyc++;
      if (pend != 0) begin
        case (pend)
          255: chk("fc after frame 255", small_if.frame_count, 8'd255);
          256: chk("fc after frame 256", small_if.frame_count, 8'd0);
          257: chk("fc after frame 257", small_if.frame_count, 8'd1);
          default: ;
        endcase
        pend = 0;
      end
      if (small_if.done === 1'b1 && dn < 257) begin
        dn++;
        if (dn > 1 && cyc - last != 18) bad++;
        last = cyc;
        pend = dn;
      end
    end
    start_v[1] = 1'b0;
    chk("frames completed", dn, 257);
    chk("period mismatches", bad, 0);
    repeat (25) tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
